prores_golomb_coder: RTL and testbench
======================================

Name: prores_golomb_coder

Overview:
- Pipelined codeword generator for the ProRes entropy coder (DC/AC run and level coding).
- Per valid input it produces either a Golomb-Rice or an Exp-Golomb codeword of order k.
- Output is the codeword value (sum) right-aligned, plus its total bit length (leading zeros are implied by the length).
- Sits between the run/level classifiers and the bit packer; fixed latency of 2 clocks, so Rice and Exp-Golomb results stay aligned.

Parameters:
- DW, 32, width of val, sum and codeword_length.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- input_valid  in  1  val/controls are valid this cycle.
- input_start  in  1  first-item-of-block marker (sideband).
- input_end  in  1  last-item-of-block marker (sideband).
- code_sel  in  1  0 = Golomb-Rice, 1 = Exp-Golomb.
- val  in  DW  unsigned value n to code (caller pre-adjusts, e.g. run-3 or |level|-1).
- k  in  3  code order, 0..7.
- is_add_setbit  in  2  Exp-Golomb only: extra escape zeros prepended, 0..3.
- is_ac_level  in  1  append one sign bit after the codeword.
- is_minus_n  in  1  sign bit value (1 = negative); used only when is_ac_level=1.
- output_valid  out  1  result valid.
- output_start  out  1  input_start delayed 2 clocks.
- output_end  out  1  input_end delayed 2 clocks.
- sum_n  out  DW  codeword value, right-aligned.
- codeword_length  out  DW  total codeword bits, including leading zeros.

Behaviour:
- Reset (async, reset_n=0): all pipeline registers and all outputs go to 0 immediately.
- Latency:
  - Inputs sampled at edge T; outputs valid after edge T+2.
  - Fully pipelined, accepts one input per clock, no backpressure.
- output_start/output_end: pure 2-stage delays of input_start/input_end, independent of input_valid.
- When output_valid=0: sum_n=0 and codeword_length=0.
- Golomb-Rice (code_sel=0):
  - q = n>>k.
  - Codeword = q zeros, then a 1, then the k LSBs of n.
  - sum = (1<<k) | (n & ((1<<k)-1)).
  - len = q+1+k.
  - is_add_setbit is ignored.
- Exp-Golomb (code_sel=1):
  - m = n + (1<<k); p = index of the MSB of m.
  - sum = m.
  - len = 2p - k + 1 + is_add_setbit (escape zeros change the length only, not the sum).
- Sign (is_ac_level=1), either mode: sum = (sum<<1) | is_minus_n; len = len + 1.
- Width rules:
  - Caller guarantees n + (1<<k) < 2^30, so the shifted sum fits DW.
  - len may exceed 32 for large Rice q; it is computed exactly in DW bits, with no saturation.
- Pipeline:
  - Stage 1 registers n, k, mode, flags, q, and m plus its MSB index.
  - Stage 2 assembles sum and len.
- Reset asserted mid-stream flushes all in-flight items; nothing is output for them after release.

Decomposition:
- Shared package holds:
  - DW;
  - code_sel encodings (CODE_RICE=0, CODE_EXPG=1);
  - max k (7) and max escape (3).
- One natural sub-module: msb_index, a combinational priority encoder returning the MSB position of a DW-bit value (used for p).
- Rice and Exp-Golomb datapaths stay inline and share the pipeline registers.

Test Plan:
- Rice k=0, n=2 -> after 2 clk: sum_n=1, codeword_length=3 ("001"). Rice k=1, n=3 -> sum_n=3, len=3 ("011").
- ExpG k=0, n=0 -> sum_n=1, len=1. ExpG k=0, n=3 -> sum_n=4, len=5 ("00100").
- ExpG k=1, n=0, is_add_setbit=3 -> sum_n=2, len=5 ("00010"). ExpG k=2, n=4, is_add_setbit=2 -> sum_n=8, len=7.
- Sign: ExpG k=0, n=1, is_ac_level=1, is_minus_n=1 -> sum_n=5, len=4. Same with Rice k=0, n=0 -> sum_n=3, len=2.
- Back-to-back valid each clock, alternating code_sel, with a single-cycle input_start on the first item and input_end on the last:
  - outputs appear in order, exactly 2 clk later;
  - output_start/output_end are each one cycle wide and aligned with their items;
  - idle cycles give sum_n=0, codeword_length=0.
- Assert reset_n low while 2 items are in flight -> all outputs 0 immediately; no stale output_valid after release.

Source files
------------

// File: rtl/prores_golomb_coder_pkg.sv
// Shared constants for the ProRes Golomb-Rice / Exp-Golomb codeword generator.
package prores_golomb_coder_pkg;

    localparam int GC_DW = 32;

    localparam logic CODE_RICE = 1'b0;
    localparam logic CODE_EXPG = 1'b1;

    localparam int K_MAX   = 7;
    localparam int ESC_MAX = 3;
    localparam int K_W     = $clog2(K_MAX + 1);
    localparam int ESC_W   = $clog2(ESC_MAX + 1);

endpackage

// File: rtl/prores_golomb_coder_msb_index.sv
// Combinational priority encoder: bit position of the highest set bit (0 for an all-zero value).
module prores_golomb_coder_msb_index #(
    parameter int DW = 32,
    parameter int IW = $clog2(DW)
) (
    input  logic [DW-1:0] value,
    output logic [IW-1:0] index
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        index = '0;
        for (int i = 0; i < DW; i++) begin
            index = value[i] ? IW'(i) : index;
        end
    end

endmodule

// File: rtl/prores_golomb_coder.sv
// Two-stage codeword generator: stage 1 registers operands with quotient and m/MSB,
// stage 2 assembles the right-aligned codeword value and its total bit length.
module prores_golomb_coder
    import prores_golomb_coder_pkg::*;
#(
    parameter int DW = GC_DW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             input_valid,
    input  logic             input_start,
    input  logic             input_end,
    input  logic             code_sel,
    input  logic [DW-1:0]    val,
    input  logic [K_W-1:0]   k,
    input  logic [ESC_W-1:0] is_add_setbit,
    input  logic             is_ac_level,
    input  logic             is_minus_n,
    output logic             output_valid,
    output logic             output_start,
    output logic             output_end,
    output logic [DW-1:0]    sum_n,
    output logic [DW-1:0]    codeword_length
);

    localparam int PW = $clog2(DW);
    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    logic             s1_valid_d, s1_valid_q;
    logic             s1_start_d, s1_start_q;
    logic             s1_end_d,   s1_end_q;
    logic             s1_sel_d,   s1_sel_q;
    logic [DW-1:0]    s1_n_d,     s1_n_q;
    logic [K_W-1:0]   s1_k_d,     s1_k_q;
    logic [ESC_W-1:0] s1_esc_d,   s1_esc_q;
    logic             s1_ac_d,    s1_ac_q;
    logic             s1_minus_d, s1_minus_q;
    logic [DW-1:0]    s1_quot_d,  s1_quot_q;
    logic [DW-1:0]    s1_m_d,     s1_m_q;
    logic [PW-1:0]    s1_p_d,     s1_p_q;

    logic             out_valid_d, out_valid_q;
    logic             out_start_d, out_start_q;
    logic             out_end_d,   out_end_q;
    logic [DW-1:0]    out_sum_d,   out_sum_q;
    logic [DW-1:0]    out_len_d,   out_len_q;

    logic [DW-1:0]    base_sum_s, base_len_s;
    logic [DW-1:0]    full_sum_s, full_len_s;
    logic [DW-1:0]    rice_mask_s;

    prores_golomb_coder_msb_index #(.DW(DW), .IW(PW)) u_msb_index (
        .value (s1_m_d),
        .index (s1_p_d)
    );

    // Stage 1 operands: quotient for Rice, m = n + 2^k for Exp-Golomb.
    always_comb begin
        s1_valid_d = input_valid;
        s1_start_d = input_start;
        s1_end_d   = input_end;
        s1_sel_d   = code_sel;
        s1_n_d     = val;
        s1_k_d     = k;
        s1_esc_d   = is_add_setbit;
        s1_ac_d    = is_ac_level;
        s1_minus_d = is_minus_n;
        s1_quot_d  = val >> k;
        s1_m_d     = val + (ONE << k);
    end

    // Stage 2: codeword value/length, optional trailing sign bit, zeroed when idle.
    always_comb begin
        rice_mask_s = (ONE << s1_k_q) - ONE;
        base_sum_s  = '0;
        base_len_s  = '0;
        case (s1_sel_q)
            CODE_RICE: begin
                base_sum_s = (ONE << s1_k_q) | (s1_n_q & rice_mask_s);
                base_len_s = s1_quot_q + ONE + DW'(s1_k_q);
            end
            CODE_EXPG: begin
                base_sum_s = s1_m_q;
                base_len_s = (DW'(s1_p_q) << 1) - DW'(s1_k_q) + ONE + DW'(s1_esc_q);
            end
            default: begin
                base_sum_s = '0;
                base_len_s = '0;
            end
        endcase

        if (s1_ac_q) begin
            full_sum_s = {base_sum_s[DW-2:0], s1_minus_q};
            full_len_s = base_len_s + ONE;
        end else begin
            full_sum_s = base_sum_s;
            full_len_s = base_len_s;
        end

        out_valid_d = s1_valid_q;
        out_start_d = s1_start_q;
        out_end_d   = s1_end_q;
        out_sum_d   = s1_valid_q ? full_sum_s : '0;
        out_len_d   = s1_valid_q ? full_len_s : '0;
    end

    // Pipeline registers; async reset flushes everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_start_q  <= 1'b0;
            s1_end_q    <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_n_q      <= '0;
            s1_k_q      <= '0;
            s1_esc_q    <= '0;
            s1_ac_q     <= 1'b0;
            s1_minus_q  <= 1'b0;
            s1_quot_q   <= '0;
            s1_m_q      <= '0;
            s1_p_q      <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_end_q   <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_start_q  <= s1_start_d;
            s1_end_q    <= s1_end_d;
            s1_sel_q    <= s1_sel_d;
            s1_n_q      <= s1_n_d;
            s1_k_q      <= s1_k_d;
            s1_esc_q    <= s1_esc_d;
            s1_ac_q     <= s1_ac_d;
            s1_minus_q  <= s1_minus_d;
            s1_quot_q   <= s1_quot_d;
            s1_m_q      <= s1_m_d;
            s1_p_q      <= s1_p_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_end_q   <= out_end_d;
            out_sum_q   <= out_sum_d;
            out_len_q   <= out_len_d;
        end
    end

    assign output_valid    = out_valid_q;
    assign output_start    = out_start_q;
    assign output_end      = out_end_q;
    assign sum_n           = out_sum_q;
    assign codeword_length = out_len_q;

endmodule

// File: tb/tb_prores_golomb_coder.sv
// Self-checking bench for prores_golomb_coder: directed, random, back-to-back and reset-flush scenarios.
module tb_prores_golomb_coder;

    typedef struct {
        bit          v;
        bit          st;
        bit          en;
        bit          sel;
        int unsigned n;
        int          k;
        int          esc;
        bit          ac;
        bit          mi;
    } item_t;

    logic        clk;
    logic        reset_n;
    logic        input_valid, input_start, input_end, code_sel;
    logic [31:0] val;
    logic [2:0]  k;
    logic [1:0]  is_add_setbit;
    logic        is_ac_level, is_minus_n;
    logic        output_valid, output_start, output_end;
    logic [31:0] sum_n, codeword_length;

    int n_checks = 0;
    int n_fail   = 0;

    prores_golomb_coder #(.DW(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .input_valid     (input_valid),
        .input_start     (input_start),
        .input_end       (input_end),
        .code_sel        (code_sel),
        .val             (val),
        .k               (k),
        .is_add_setbit   (is_add_setbit),
        .is_ac_level     (is_ac_level),
        .is_minus_n      (is_minus_n),
        .output_valid    (output_valid),
        .output_start    (output_start),
        .output_end      (output_end),
        .sum_n           (sum_n),
        .codeword_length (codeword_length)
    );

    always #5 clk = ~clk;

    // Reference model straight from the coding rules, in wide arithmetic.
    function automatic logic [66:0] expect_out(input item_t it);
        longint s, l, m;
        int p;
        logic [31:0] s32, l32;
        if (!it.sel) begin
            s = (64'sd1 << it.k) + (longint'(it.n) % (64'sd1 << it.k));
            l = (longint'(it.n) >> it.k) + 1 + it.k;
        end else begin
            m = longint'(it.n) + (64'sd1 << it.k);
            p = 0;
            while ((m >> (p + 1)) != 0) p++;
            s = m;
            l = 2 * p - it.k + 1 + it.esc;
        end
        if (it.ac) begin
            s = s * 2 + (it.mi ? 1 : 0);
            l = l + 1;
        end
        s32 = s[31:0];
        l32 = l[31:0];
        if (it.v) return {1'b1, it.st, it.en, s32, l32};
        else      return {1'b0, it.st, it.en, 32'd0, 32'd0};
    endfunction

    function automatic item_t mk(input bit v, input bit sel, input int unsigned n, input int kk,
                                 input int esc, input bit ac, input bit mi);
        item_t it;
        it.v = v; it.st = 1'b0; it.en = 1'b0; it.sel = sel; it.n = n;
        it.k = kk; it.esc = esc; it.ac = ac; it.mi = mi;
        return it;
    endfunction

    task automatic drive(input item_t it);
        input_valid   = it.v;
        input_start   = it.st;
        input_end     = it.en;
        code_sel      = it.sel;
        val           = it.n;
        k             = 3'(it.k);
        is_add_setbit = 2'(it.esc);
        is_ac_level   = it.ac;
        is_minus_n    = it.mi;
    endtask

    task automatic test_reset();
        logic [66:0] obs;
        reset_n = 1'b0;
        drive(mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        #1;
        obs = {output_valid, output_start, output_end, sum_n, codeword_length};
        n_checks++;
        if (obs !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h, want 0", obs);
        end
        repeat (3) @(negedge clk);
        obs = {output_valid, output_start, output_end, sum_n, codeword_length};
        n_checks++;
        if (obs !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %h, want 0", obs);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        item_t q[$];
        item_t tab[$];
        logic [66:0] obs, exp;
        tab.push_back(mk(1'b1, 1'b0, 2,   0, 0, 1'b0, 1'b0)); // Rice "001"
        tab.push_back(mk(1'b1, 1'b0, 3,   1, 0, 1'b0, 1'b0)); // Rice "011"
        tab.push_back(mk(1'b1, 1'b1, 0,   0, 0, 1'b0, 1'b0));
        tab.push_back(mk(1'b1, 1'b1, 3,   0, 0, 1'b0, 1'b0)); // ExpG "00100"
        tab.push_back(mk(1'b1, 1'b1, 0,   1, 3, 1'b0, 1'b0));
        tab.push_back(mk(1'b1, 1'b1, 4,   2, 2, 1'b0, 1'b0));
        tab.push_back(mk(1'b1, 1'b1, 1,   0, 0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 1'b0, 0,   0, 0, 1'b1, 1'b1));
        tab.push_back(mk(1'b1, 1'b0, 5,   2, 3, 1'b0, 1'b0)); // escape ignored in Rice
        tab.push_back(mk(1'b1, 1'b1, 0,   7, 0, 1'b0, 1'b0)); // max k
        tab.push_back(mk(1'b1, 1'b0, 100, 0, 0, 1'b1, 1'b0)); // length beyond 32
        foreach (tab[i]) begin
            q.push_back(tab[i]);
            q.push_back(mk(1'b0, 1'b1, 7, 3, 1, 1'b1, 1'b1)); // idle with junk data
        end
        for (int c = 0; c < q.size() + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                obs = {output_valid, output_start, output_end, sum_n, codeword_length};
                exp = expect_out(q[c-2]);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL directed[%0d]: got v%b s%b e%b sum=%0d len=%0d, want v%b s%b e%b sum=%0d len=%0d",
                             c - 2, obs[66], obs[65], obs[64], obs[63:32], obs[31:0],
                             exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
                end
            end
            drive(c < q.size() ? q[c] : mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_random();
        item_t q[$];
        item_t it;
        logic [66:0] obs, exp;
        for (int i = 0; i < 300; i++) begin
            it.v   = ($urandom_range(0, 3) != 0);
            it.st  = $urandom_range(0, 1);
            it.en  = $urandom_range(0, 1);
            it.sel = $urandom_range(0, 1);
            it.k   = $urandom_range(0, 7);
            it.esc = $urandom_range(0, 3);
            it.ac  = $urandom_range(0, 1);
            it.mi  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 0) it.n = $urandom_range(0, 1000);
            else                           it.n = $urandom_range(0, (1 << 30) - 129);
            q.push_back(it);
        end
        for (int c = 0; c < q.size() + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                obs = {output_valid, output_start, output_end, sum_n, codeword_length};
                exp = expect_out(q[c-2]);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got v%b s%b e%b sum=%0d len=%0d, want v%b s%b e%b sum=%0d len=%0d",
                             c - 2, obs[66], obs[65], obs[64], obs[63:32], obs[31:0],
                             exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
                end
            end
            drive(c < q.size() ? q[c] : mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        item_t q[$];
        item_t it;
        logic [66:0] obs, exp;
        q.push_back(mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            it = mk(1'b1, i[0], 32'(i * 37 + 5), i % 8, i % 4, i[1], i[2]);
            it.st = (i == 0);
            it.en = (i == 7);
            q.push_back(it);
        end
        q.push_back(mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        q.push_back(mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        for (int c = 0; c < q.size() + 2; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                obs = {output_valid, output_start, output_end, sum_n, codeword_length};
                exp = expect_out(q[c-2]);
                n_checks++;
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v%b s%b e%b sum=%0d len=%0d, want v%b s%b e%b sum=%0d len=%0d",
                             c - 2, obs[66], obs[65], obs[64], obs[63:32], obs[31:0],
                             exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
                end
            end
            drive(c < q.size() ? q[c] : mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_flush();
        item_t a, b;
        logic [66:0] obs;
        a = mk(1'b1, 1'b1, 3, 0, 0, 1'b0, 1'b0);
        a.st = 1'b1;
        b = mk(1'b1, 1'b0, 9, 2, 0, 1'b0, 1'b0);
        b.en = 1'b1;
        @(negedge clk);
        drive(a);
        @(negedge clk);
        drive(b);
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0));
        n_checks++;
        if (output_valid !== 1'b1 || sum_n !== 32'd4) begin
            n_fail++;
            $display("FAIL flush_pre: got valid=%b sum=%0d, want valid=1 sum=4", output_valid, sum_n);
        end
        reset_n = 1'b0;
        #1;
        obs = {output_valid, output_start, output_end, sum_n, codeword_length};
        n_checks++;
        if (obs !== 67'd0) begin
            n_fail++;
            $display("FAIL flush_async: got %h, want 0", obs);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            obs = {output_valid, output_start, output_end, sum_n, codeword_length};
            n_checks++;
            if (obs !== 67'd0) begin
                n_fail++;
                $display("FAIL flush_after[%0d]: got %h, want 0", c, obs);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
